// File: rtl/syncfifo_flags.sv
// -----------------------------------------------------------------------------
// syncfifo_flags
//
// Single-clock show-ahead FIFO with an occupancy count, programmable
// almost-full / almost-empty thresholds and optional sticky error flags.
// Used between pipeline stages where back-pressure and early warning are
// needed but no clock crossing is involved.
//
// Parameters:
//   DATA_WIDTH    word width in bits
//   ADDR_WIDTH    log2 of depth (DEPTH = 1 << ADDR_WIDTH)
//   AFULL_THRESH  almost_full  when count >= this (1..DEPTH)
//   AEMPTY_THRESH almost_empty when count <= this (0..DEPTH-1)
//
// Ports:
//   clk          single clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   wpush/wdata  write request and word; ignored while wfull
//   wfull        FIFO holds DEPTH words
//   rpull        read request, pops the head; ignored while rempty
//   rdata        head word (show-ahead), 0 while rempty
//   rempty       FIFO holds 0 words
//   count        occupancy 0..DEPTH
//   almost_full  count >= AFULL_THRESH
//   almost_empty count <= AEMPTY_THRESH
//   overflow     sticky: push attempted while full
//   underflow    sticky: pull attempted while empty
//   err_clr      synchronous clear of overflow/underflow
//
// Build option:
//   SYNCFIFO_ERR_FLAGS_EN  when defined, overflow/underflow are sticky flag
//                          registers; when undefined they are tied 0 and
//                          err_clr is ignored. The data path is identical.
// -----------------------------------------------------------------------------
module syncfifo_flags #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wpush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  input  logic                  rpull,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("syncfifo_flags: ADDR_WIDTH=%0d out of range 1..30", ADDR_WIDTH);
  end

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("syncfifo_flags: DATA_WIDTH must be at least 1");
  end

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("syncfifo_flags: AFULL_THRESH=%0d out of range 1..%0d",
           AFULL_THRESH, DEPTH);
  end

  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("syncfifo_flags: AEMPTY_THRESH=%0d out of range 0..%0d",
           AEMPTY_THRESH, DEPTH - 1);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;

  logic push_ok;
  logic pull_ok;

  // ---------------------------------------------------------------------------
  // Flags decode from the count register only, so they never react
  // combinationally to wpush/rpull.
  // ---------------------------------------------------------------------------
  assign count        = count_q;
  assign wfull        = (count_q == DEPTH_C);
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  // Show-ahead head word, forced to zero while empty.
  assign rdata = rempty ? '0 : mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    push_ok  = wpush & ~wfull;
    pull_ok  = rpull & ~rempty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pull_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pull_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale words are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef SYNCFIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Clear first, then set, so a set condition in the same cycle as
  // err_clr wins and the flag stays high.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wpush & wfull) begin
      overflow_d = 1'b1;
    end
    if (rpull & rempty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_syncfifo_flags.sv
// -----------------------------------------------------------------------------
// tb_syncfifo_flags
//
// Directed bench for syncfifo_flags (DATA_WIDTH=32, ADDR_WIDTH=4, default
// thresholds 14/2). The stimulus process pushes each word it expects to
// read back into a scoreboard queue; a monitor process pops and compares
// whenever the DUT accepts a pull. Occupancy/flag checks are made by the
// stimulus process after each edge. Expected error-flag values follow the
// SYNCFIFO_ERR_FLAGS_EN build option.
// -----------------------------------------------------------------------------
module tb_syncfifo_flags;

`ifdef SYNCFIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        wpush;
  logic [31:0] wdata;
  logic        wfull;
  logic        rpull;
  logic [31:0] rdata;
  logic        rempty;
  logic [4:0]  count;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
  logic        err_clr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] exp_q[$];

  syncfifo_flags #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wpush        (wpush),
    .wdata        (wdata),
    .wfull        (wfull),
    .rpull        (rpull),
    .rdata        (rdata),
    .rempty       (rempty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {count, wfull, rempty, almost_full, almost_empty} for occupancy c,
  // thresholds 14 and 2, depth 16.
  function automatic logic [31:0] exp_status(input int c);
    return {23'd0, 5'(c), (c == 16), (c == 0), (c >= 14), (c <= 2)};
  endfunction

  function automatic logic [31:0] act_status();
    return {23'd0, count, wfull, rempty, almost_full, almost_empty};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pull is accepted at the coming edge, so the
  // head word shown now must be the oldest expected word.
  always @(negedge clk) begin
    if (!rst && rpull && !rempty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got 0x%0h expected no word at %0t", rdata, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata_order: got 0x%0h expected 0x%0h at %0t", rdata, e, $time);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    wpush   = 1'b0;
    wdata   = '0;
    rpull   = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted mid-clock with data queued takes effect immediately.
    wpush = 1'b1; wdata = 32'd11; exp_q.push_back(32'd11); tick();
    wdata = 32'd12; exp_q.push_back(32'd12); tick();
    wpush = 1'b0;
    chk("pre_reset_status", act_status(), exp_status(2));
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("reset_status", act_status(), exp_status(0));
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_errflags", {30'd0, overflow, underflow}, 32'd0);
    tick();
    rst = 1'b0;

    // Fill with i+2, then one dropped push of 99.
    for (int i = 0; i < 16; i++) begin
      wpush = 1'b1; wdata = 32'(i + 2); exp_q.push_back(32'(i + 2));
      tick();
      chk("fill_status", act_status(), exp_status(i + 1));
    end
    wdata = 32'd99;
    tick();
    wpush = 1'b0;
    chk("overfill_status", act_status(), exp_status(16));
    chk("overflow_flags", {30'd0, overflow, underflow}, {30'd0, ERR_EN, 1'b0});

    // Drain 2..17, then one extra pull while empty.
    rpull = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_status", act_status(), exp_status(15 - i));
    end
    chk("empty_rdata", rdata, 32'd0);
    tick();
    rpull = 1'b0;
    chk("underpull_status", act_status(), exp_status(0));
    chk("underflow_flags", {30'd0, overflow, underflow}, {30'd0, ERR_EN, ERR_EN});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_flags", {30'd0, overflow, underflow}, 32'd0);

    // Stream across pointer wrap at a steady count of 5.
    for (int i = 0; i < 5; i++) begin
      wpush = 1'b1; wdata = 32'(100 + i); exp_q.push_back(32'(100 + i));
      tick();
    end
    chk("stream_prefill", act_status(), exp_status(5));
    rpull = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 32'(105 + i); exp_q.push_back(32'(105 + i));
      tick();
      chk("stream_status", act_status(), exp_status(5));
    end
    wpush = 1'b0;
    repeat (5) tick();
    rpull = 1'b0;
    chk("stream_drained", act_status(), exp_status(0));

    // Full FIFO with push and pull together: pull wins, push dropped.
    for (int i = 0; i < 16; i++) begin
      wpush = 1'b1; wdata = 32'(200 + i); exp_q.push_back(32'(200 + i));
      tick();
    end
    chk("refill_status", act_status(), exp_status(16));
    wdata = 32'd77; rpull = 1'b1;
    tick();
    wpush = 1'b0; rpull = 1'b0;
    chk("full_both_status", act_status(), exp_status(15));
    chk("full_both_flags", {30'd0, overflow, underflow}, {30'd0, ERR_EN, 1'b0});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr2_flags", {30'd0, overflow, underflow}, 32'd0);

    // Down to 7, then reset mid-stream.
    rpull = 1'b1;
    repeat (8) tick();
    rpull = 1'b0;
    chk("pre_reset2_status", act_status(), exp_status(7));
    chk("pre_reset2_head", rdata, 32'd209);
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("reset2_status", act_status(), exp_status(0));
    chk("reset2_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;

    wpush = 1'b1; wdata = 32'hA5; exp_q.push_back(32'hA5);
    tick();
    wpush = 1'b0;
    chk("post_reset_rdata", rdata, 32'hA5);
    chk("post_reset_status", act_status(), exp_status(1));
    rpull = 1'b1;
    tick();
    rpull = 1'b0;
    chk("final_status", act_status(), exp_status(0));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syncfifo_flags.md
# syncfifo_flags

Single-clock, parametrised FIFO that generalises the team's async FIFO handshake (`wpush`/`wfull`, `rpull`/`rempty`, show-ahead `rdata`) for use inside one clock domain. It adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- optional sticky overflow/underflow error flags.

It sits between pipeline stages of the core, such as fetch-to-decode buffering and store/load queues, where no clock crossing is needed but back-pressure and early-warning flags are.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width in bits.
- `ADDR_WIDTH`, 4, log2 of depth; `DEPTH = 1 << ADDR_WIDTH`.
- `AFULL_THRESH`, `DEPTH-2`, `almost_full` asserts when count >= this; legal range 1..DEPTH.
- `AEMPTY_THRESH`, 2, `almost_empty` asserts when count <= this; legal range 0..DEPTH-1.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset. This is decided: one clock, async active-high reset.
- `wpush`  in  1  write request.
- `wdata`  in  DATA_WIDTH  write word.
- `wfull`  out  1  FIFO holds DEPTH words.
- `rpull`  in  1  read request; pops the current head.
- `rdata`  out  DATA_WIDTH  head word, valid whenever `rempty`=0.
- `rempty`  out  1  FIFO holds 0 words.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  count >= AFULL_THRESH.
- `almost_empty`  out  1  count <= AEMPTY_THRESH.
- `overflow`  out  1  sticky: push attempted while full.
- `underflow`  out  1  sticky: pull attempted while empty.
- `err_clr`  in  1  synchronous clear of `overflow`/`underflow`.

## Operation
- Storage: DEPTH x DATA_WIDTH register array. Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH naturally. The count register is ADDR_WIDTH+1 bits.
- Push acceptance: `push_ok = wpush & ~wfull`. An accepted push writes `wdata` at the write pointer, then the write pointer increments.
- Pull acceptance: `pull_ok = rpull & ~rempty`. An accepted pull increments the read pointer.
- Count update:
  - +1 on push only;
  - -1 on pull only;
  - unchanged when both are accepted, or when neither is.
- Simultaneous push and pull on a non-empty, non-full FIFO: both are accepted and ordering is preserved.
- Full/empty interaction: `wfull` blocks push even when `rpull` is high in the same cycle; `rempty` blocks pull even when `wpush` is high.
- Rejected requests change no pointer, count or memory.
- Flag derivation: `wfull`, `rempty`, `almost_full` and `almost_empty` are decoded from the count register only. They therefore change only after a clock edge and never combinationally from `wpush`/`rpull`.
- Read data (show-ahead): `rdata = mem[rd_ptr]` while `rempty`=0. `rdata` is forced to 0 while `rempty`=1.
- Parameters outside their legal ranges trigger an elaboration-time `$error`.

## Timing
- Reset (`rst`=1, asynchronous), output values:
  - `count`=0, `rempty`=1, `wfull`=0, `rdata`=0;
  - `almost_empty`=1;
  - `almost_full`=0;
  - `overflow`=0, `underflow`=0.
- Reset effect on state: pointers are cleared and memory contents are not cleared.
- Reset mid-operation: every queued word is discarded immediately and the outputs above take effect without waiting for a clock edge.
- Release: the first edge after `rst` falls may accept a push.
- Push-to-read latency: for a push accepted at edge T into an empty FIFO, `rempty` falls and `rdata` is valid after T, so the word is pullable at edge T+1.
- Pull latency: a pull at edge T presents the next word (or `rempty`=1) after T.
- Full-to-not-full: a pull at edge T lowers `wfull` after T, and a push is accepted at T+1.

## Configuration
- Macro: `SYNCFIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` sets on any edge with `wpush & wfull`;
  - `underflow` sets on any edge with `rpull & rempty`;
  - both flags stay set until `err_clr` is sampled high or `rst` asserts;
  - a set condition and `err_clr` in the same cycle leave the flag set.
- Undefined: `overflow` and `underflow` are tied 0, `err_clr` is ignored, and no flag registers are built.
- FIFO data path behaviour is identical in both builds.

## Test plan
All scenarios use DATA_WIDTH=32, ADDR_WIDTH=4, defaults otherwise, and the macro defined.
- Reset: assert `rst` mid-clock → immediately `rempty`=1, `wfull`=0, `count`=0, `rdata`=0, `almost_empty`=1, `almost_full`=0, both error flags 0.
- Fill: push 16 words i+2 (i=0..15) → `almost_empty` drops at count 3, `almost_full` rises at count 14, `wfull`=1 at count 16. A 17th push (value 99) is dropped, `count` stays 16 and `overflow`=1.
- Drain: pull 16 times → `rdata` sequence 2..17 in order, `rempty`=1 after the 16th pull. A 17th pull sets `underflow`=1 and `count` stays 0. Then `err_clr` for 1 cycle → both flags 0.
- Stream/wrap: at count 5, drive push and pull together for 40 cycles with incrementing data → `count` stays 5 every cycle and all 45 words are read in order across pointer wrap.
- Full plus simultaneous request: at count 16, `wpush`=1 and `rpull`=1 → the pull pops the head, the push is dropped, `count`=15, `overflow`=1.
- Reset mid-stream: at count 7 assert `rst` for 1 cycle → queue empty. Next push of 0xA5 → `rdata`=0xA5 after 1 edge and `count`=1.
